reg_wb_sched: RTL and testbench



---
 rtl/reg_wb_sched_if.sv | 39 +++
 rtl/reg_wb_sched.sv | 198 +++++++++++++++++++
 tb/tb_reg_wb_sched.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_sched_if.sv
// Bus bundle between the WB stage / multicycle unit, the issue logic and the
// register-file write port. The slave modport is the scheduler's view.
interface reg_wb_sched_if;
    logic        pipe_we;
    logic [4:0]  pipe_reg;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic [4:0]  mc_reg;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  iss_rs;
    logic [4:0]  iss_rt;
    logic        iss_stall;
    logic        pipe_hold;
    logic [31:0] wr_data;
    logic [4:0]  wr_reg;
    logic        reg_write;
    logic [31:0] busy;

    modport slave (
        input  pipe_we, pipe_reg, pipe_data,
        input  mc_valid, mc_reg, mc_data,
        output mc_ready,
        input  iss_valid, iss_rd, iss_rs, iss_rt,
        output iss_stall, pipe_hold,
        output wr_data, wr_reg, reg_write, busy
    );

    modport master (
        output pipe_we, pipe_reg, pipe_data,
        output mc_valid, mc_reg, mc_data,
        input  mc_ready,
        output iss_valid, iss_rd, iss_rs, iss_rt,
        input  iss_stall, pipe_hold,
        input  wr_data, wr_reg, reg_write, busy
    );
endinterface

// File: rtl/reg_wb_sched.sv
// Register-file write-port scheduler: pipeline writeback has fixed priority,
// multicycle results queue in a small FIFO, a busy scoreboard produces the
// issue stall, and a starvation FSM requests pipeline hold when the FIFO head
// is blocked too long.
module reg_wb_sched #(
    parameter int unsigned MC_DEPTH     = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    reg_wb_sched_if.slave  bus
);

    localparam int unsigned AW = $clog2(MC_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MC_DEPTH);
    localparam logic [SW-1:0] LAST_CNT = SW'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STARVED
    } state_t;

    logic [4:0]    mem_reg  [MC_DEPTH];
    logic [31:0]   mem_data [MC_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    logic          pipe_act;
    logic          fifo_empty;
    logic          fifo_ready;
    logic          push;
    logic          pop;
    logic          blocked;
    logic          stall;
    logic          iss_fire;
    logic [4:0]    head_reg;
    logic [31:0]   head_data;

    logic [31:0]   busy_q;
    logic [31:0]   set_mask;
    logic [31:0]   clr_mask;

    logic          reg_write_q;
    logic [4:0]    wr_reg_q;
    logic [31:0]   wr_data_q;

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic          hold_q;

    assign pipe_act   = bus.pipe_we & (bus.pipe_reg != '0);
    assign fifo_empty = (count == '0);
    assign fifo_ready = (count != FULL_CNT);
    // r0 results complete the handshake but never enter the FIFO
    assign push       = bus.mc_valid & fifo_ready & (bus.mc_reg != '0);
    assign pop        = ~pipe_act & ~fifo_empty;
    assign blocked    = pipe_act & ~fifo_empty;
    assign head_reg   = mem_reg[rd_ptr];
    assign head_data  = mem_data[rd_ptr];

    // busy[0] is never set, so r0 operands never stall
    assign stall    = bus.iss_valid &
                      (busy_q[bus.iss_rs] | busy_q[bus.iss_rt] | busy_q[bus.iss_rd]);
    assign iss_fire = bus.iss_valid & ~stall;

    assign bus.mc_ready  = fifo_ready;
    assign bus.iss_stall = stall;
    assign bus.pipe_hold = hold_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_reg    = wr_reg_q;
    assign bus.reg_write = reg_write_q;
    assign bus.busy      = busy_q;

    // FIFO occupancy after this edge, used by the starvation FSM
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Scoreboard set/clear masks for this cycle
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_fire && (bus.iss_rd != '0)) begin
            set_mask[bus.iss_rd] = 1'b1;
        end
        if (pop) begin
            clr_mask[head_reg] = 1'b1;
        end
    end

    // Multicycle result FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr]  <= bus.mc_reg;
                mem_data[wr_ptr] <= bus.mc_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    // Write-port arbitration: pipeline first, then FIFO head
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
        end else if (pipe_act) begin
            reg_write_q <= 1'b1;
            wr_reg_q    <= bus.pipe_reg;
            wr_data_q   <= bus.pipe_data;
        end else if (pop) begin
            reg_write_q <= 1'b1;
            wr_reg_q    <= head_reg;
            wr_data_q   <= head_data;
        end else begin
            reg_write_q <= 1'b0;
        end
    end

    // Busy scoreboard; a same-cycle set overrides a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_mask) | set_mask;
        end
    end

    // Starvation FSM: counts consecutive cycles the FIFO head loses arbitration.
    // IDLE and WAIT share the counting path; IDLE simply starts from zero, so the
    // first blocked cycle after a push into an empty FIFO is counted as well.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            hold_q     <= 1'b0;
        end else if (count_next == '0) begin
            state      <= IDLE;
            starve_cnt <= '0;
            hold_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, WAIT: begin
                    if (blocked) begin
                        if (starve_cnt == LAST_CNT) begin
                            state      <= STARVED;
                            starve_cnt <= '0;
                            hold_q     <= 1'b1;
                        end else begin
                            state      <= WAIT;
                            starve_cnt <= starve_cnt + 1'b1;
                            hold_q     <= 1'b0;
                        end
                    end else begin
                        state      <= WAIT;
                        starve_cnt <= '0;
                        hold_q     <= 1'b0;
                    end
                end
                STARVED: begin
                    if (pop) begin
                        state      <= WAIT;
                        starve_cnt <= '0;
                        hold_q     <= 1'b0;
                    end else begin
                        state      <= STARVED;
                        hold_q     <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    starve_cnt <= '0;
                    hold_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed bench for reg_wb_sched: expected register-file writes are queued as
// stimulus is issued and checked by an independent write monitor; scoreboard,
// backpressure and hold outputs are checked inline.
module tb_reg_wb_sched;

    logic clk;
    logic rst;

    reg_wb_sched_if bus ();

    reg_wb_sched #(
        .MC_DEPTH     (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  checks = 0;
    int  errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Write monitor: every reg_write must match the next expected write
    always @(negedge clk) begin
        if (bus.reg_write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got r%0d 0x%08h required no write",
                         bus.wr_reg, bus.wr_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.wr_reg !== e.r || bus.wr_data !== e.d) begin
                    errors++;
                    $display("FAIL sb_write got r%0d 0x%08h required r%0d 0x%08h",
                             bus.wr_reg, bus.wr_data, e.r, e.d);
                end
            end
        end
    end

    task automatic exp_push(input logic [4:0] r, input logic [31:0] d);
        wr_t w;
        w.r = r;
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pipe_we   = 1'b0;
        bus.pipe_reg  = '0;
        bus.pipe_data = '0;
        bus.mc_valid  = 1'b0;
        bus.mc_reg    = '0;
        bus.mc_data   = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
        bus.iss_rs    = '0;
        bus.iss_rt    = '0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_reg_write"}, 32'(bus.reg_write), 32'd0);
        chk({tag, "_wr_reg"},    32'(bus.wr_reg),    32'd0);
        chk({tag, "_wr_data"},   bus.wr_data,        32'd0);
        chk({tag, "_busy"},      bus.busy,           32'd0);
        chk({tag, "_mc_ready"},  32'(bus.mc_ready),  32'd1);
        chk({tag, "_pipe_hold"}, 32'(bus.pipe_hold), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk_reset_state("reset");
        chk("reset_iss_stall", 32'(bus.iss_stall), 32'd0);

        // Priority: pipeline r5 and multicycle r6 in the same cycle
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd6;
        #1 chk("prio_issue_stall", 32'(bus.iss_stall), 32'd0);
        cyc();
        idle();
        #1 chk("prio_busy_set", bus.busy, 32'h0000_0040);
        bus.pipe_we   = 1'b1;
        bus.pipe_reg  = 5'd5;
        bus.pipe_data = 32'hAAAA_0000;
        bus.mc_valid  = 1'b1;
        bus.mc_reg    = 5'd6;
        bus.mc_data   = 32'h1234_5678;
        exp_push(5'd5, 32'hAAAA_0000);
        exp_push(5'd6, 32'h1234_5678);
        cyc();
        idle();
        #1 chk("prio_t1_wr_reg", 32'(bus.wr_reg), 32'd5);
        chk("prio_t1_busy", bus.busy, 32'h0000_0040);
        cyc();
        #1 chk("prio_t2_wr_reg", 32'(bus.wr_reg), 32'd6);
        chk("prio_t2_busy", bus.busy, 32'd0);

        // Scoreboard RAW stall on r9
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd9;
        #1 chk("sb_issue9_stall", 32'(bus.iss_stall), 32'd0);
        cyc();
        bus.iss_rd = 5'd10;
        bus.iss_rs = 5'd9;
        #1 chk("sb_raw_stall_a", 32'(bus.iss_stall), 32'd1);
        chk("sb_busy9", bus.busy, 32'h0000_0200);
        cyc();
        bus.mc_valid = 1'b1;
        bus.mc_reg   = 5'd9;
        bus.mc_data  = 32'h0000_0099;
        exp_push(5'd9, 32'h0000_0099);
        #1 chk("sb_raw_stall_b", 32'(bus.iss_stall), 32'd1);
        cyc();
        bus.mc_valid = 1'b0;
        #1 chk("sb_raw_stall_pop", 32'(bus.iss_stall), 32'd1);
        cyc();
        #1 chk("sb_raw_release", 32'(bus.iss_stall), 32'd0);
        chk("sb_busy_clear9", bus.busy, 32'd0);
        cyc();
        idle();
        #1 chk("sb_busy10", bus.busy, 32'h0000_0400);
        bus.mc_valid = 1'b1;
        bus.mc_reg   = 5'd10;
        bus.mc_data  = 32'h0000_1010;
        exp_push(5'd10, 32'h0000_1010);
        cyc();
        idle();
        cyc();
        #1 chk("sb_busy_clear10", bus.busy, 32'd0);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd0;
        #1 chk("sb_r0_stall", 32'(bus.iss_stall), 32'd0);
        cyc();
        idle();
        #1 chk("sb_r0_busy", bus.busy, 32'd0);

        // r0 handling: dropped multicycle result, r0 pipeline write lets FIFO drain
        bus.mc_valid = 1'b1;
        bus.mc_reg   = 5'd0;
        bus.mc_data  = 32'h0000_DEAD;
        #1 chk("r0_mc_ready", 32'(bus.mc_ready), 32'd1);
        cyc();
        idle();
        #1 chk("r0_after_ready", 32'(bus.mc_ready), 32'd1);
        cyc();
        #1 chk("r0_no_write", 32'(bus.reg_write), 32'd0);
        bus.pipe_we   = 1'b1;
        bus.pipe_reg  = 5'd3;
        bus.pipe_data = 32'h0000_0033;
        bus.mc_valid  = 1'b1;
        bus.mc_reg    = 5'd7;
        bus.mc_data   = 32'h0000_0077;
        exp_push(5'd3, 32'h0000_0033);
        cyc();
        idle();
        bus.pipe_we   = 1'b1;
        bus.pipe_reg  = 5'd0;
        bus.pipe_data = 32'h0000_FFFF;
        exp_push(5'd7, 32'h0000_0077);
        cyc();
        idle();
        #1 chk("r0_drain_write", 32'(bus.reg_write), 32'd1);
        chk("r0_drain_reg", 32'(bus.wr_reg), 32'd7);
        chk("r0_drain_data", bus.wr_data, 32'h0000_0077);
        cyc();

        // Full / backpressure under continuous pipeline writes
        bus.pipe_we   = 1'b1;
        bus.pipe_reg  = 5'd1;
        bus.pipe_data = 32'h0000_0100;
        bus.mc_valid  = 1'b1;
        bus.mc_reg    = 5'd11;
        bus.mc_data   = 32'h0000_00A1;
        exp_push(5'd1, 32'h0000_0100);
        #1 chk("full_ready0", 32'(bus.mc_ready), 32'd1);
        cyc();
        bus.pipe_reg  = 5'd2;
        bus.pipe_data = 32'h0000_0200;
        bus.mc_reg    = 5'd12;
        bus.mc_data   = 32'h0000_00B2;
        exp_push(5'd2, 32'h0000_0200);
        #1 chk("full_ready1", 32'(bus.mc_ready), 32'd1);
        cyc();
        bus.pipe_reg  = 5'd3;
        bus.pipe_data = 32'h0000_0300;
        bus.mc_reg    = 5'd13;
        bus.mc_data   = 32'h0000_00C3;
        exp_push(5'd3, 32'h0000_0300);
        #1 chk("full_ready2", 32'(bus.mc_ready), 32'd0);
        cyc();
        bus.pipe_reg  = 5'd4;
        bus.pipe_data = 32'h0000_0400;
        exp_push(5'd4, 32'h0000_0400);
        #1 chk("full_ready3", 32'(bus.mc_ready), 32'd0);
        cyc();
        bus.pipe_we = 1'b0;
        exp_push(5'd11, 32'h0000_00A1);
        exp_push(5'd12, 32'h0000_00B2);
        exp_push(5'd13, 32'h0000_00C3);
        #1 chk("full_ready_popcycle", 32'(bus.mc_ready), 32'd0);
        chk("full_no_hold", 32'(bus.pipe_hold), 32'd0);
        cyc();
        #1 chk("full_ready_after_pop", 32'(bus.mc_ready), 32'd1);
        cyc();
        idle();
        cyc();
        cyc();

        // Starvation: FIFO head blocked by continuous pipeline writes
        bus.pipe_we   = 1'b1;
        bus.pipe_reg  = 5'd1;
        bus.pipe_data = 32'h0000_5000;
        bus.mc_valid  = 1'b1;
        bus.mc_reg    = 5'd20;
        bus.mc_data   = 32'h0000_2020;
        exp_push(5'd1, 32'h0000_5000);
        #1 chk("starve_hold_s0", 32'(bus.pipe_hold), 32'd0);
        cyc();
        bus.mc_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus.pipe_reg  = 5'(i + 1);
            bus.pipe_data = 32'h0000_5000 + 32'(i);
            exp_push(5'(i + 1), 32'h0000_5000 + 32'(i));
            #1 chk($sformatf("starve_hold_s%0d", i), 32'(bus.pipe_hold), (i == 5) ? 32'd1 : 32'd0);
            cyc();
        end
        idle();
        exp_push(5'd20, 32'h0000_2020);
        #1 chk("starve_hold_released_pipe", 32'(bus.pipe_hold), 32'd1);
        cyc();
        #1 chk("starve_hold_fall", 32'(bus.pipe_hold), 32'd0);
        chk("starve_pop_reg", 32'(bus.wr_reg), 32'd20);
        cyc();

        // Reset mid-operation discards FIFO contents and busy bits
        bus.pipe_we   = 1'b1;
        bus.pipe_reg  = 5'd1;
        bus.pipe_data = 32'h0000_000A;
        bus.mc_valid  = 1'b1;
        bus.mc_reg    = 5'd21;
        bus.mc_data   = 32'h0000_0021;
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd22;
        exp_push(5'd1, 32'h0000_000A);
        cyc();
        bus.iss_valid = 1'b0;
        bus.iss_rd    = 5'd0;
        bus.pipe_reg  = 5'd2;
        bus.pipe_data = 32'h0000_000B;
        bus.mc_reg    = 5'd23;
        bus.mc_data   = 32'h0000_0023;
        exp_push(5'd2, 32'h0000_000B);
        cyc();
        idle();
        rst = 1'b1;
        #1 chk("rst_pre_busy", bus.busy, 32'h0040_0000);
        chk("rst_pre_full", 32'(bus.mc_ready), 32'd0);
        cyc();
        rst = 1'b0;
        #1 chk_reset_state("rst_mid");
        cyc();
        cyc();
        cyc();
        #1 chk("rst_no_stale_write", 32'(bus.reg_write), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
